issue_dispatch_unit: RTL
========================

# issue_dispatch_unit

Parametrised N-wide in-order issue stage for the streaming multiprocessor. It sits between the per-warp instruction buffer and the execution-unit ports (ALU, FPU, LSU, ...). Each cycle it issues the longest legal in-order prefix of up to ISSUE_WIDTH decoded instructions from one warp, and tracks a per-warp register scoreboard. It generalises fixed ALU+FPU dual issue to configurable width and unit count, with a runtime issue cap, warp flush and issue statistics.

## Interface
- ISSUE_WIDTH, 2: maximum instructions issued per cycle (1..4).
- NUM_UNITS, 3: execution-unit ports; unit codes 0..NUM_UNITS-1.
- NUM_WARPS, 24: warps tracked by the scoreboard.
- NUM_REGS, 64: architectural registers per warp.
- WB_PORTS, 2: writeback ports that release scoreboard entries.
- Derived widths: WID_W=$clog2(NUM_WARPS), REG_W=$clog2(NUM_REGS), UNIT_W=$clog2(NUM_UNITS), CNT_W=$clog2(ISSUE_WIDTH+1).
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  ISSUE_WIDTH  slot k holds a valid instruction; valid slots are contiguous from slot 0.
- in_warp  in  WID_W  warp owning the whole group.
- in_inst  in  ISSUE_WIDTH*64  opaque instruction payloads.
- in_unit  in  ISSUE_WIDTH*UNIT_W  target unit per slot.
- in_rd, in_rs1, in_rs2, in_rs3  in  ISSUE_WIDTH*REG_W each  register indices.
- in_wr_en  in  ISSUE_WIDTH  slot writes rd.
- in_src_en  in  ISSUE_WIDTH*3  per-slot enables for rs1, rs2, rs3.
- max_issue  in  CNT_W  runtime cap; 0 or values above ISSUE_WIDTH act as ISSUE_WIDTH.
- unit_ready  in  NUM_UNITS  unit accepts an op this cycle.
- issue_count  out  CNT_W  combinational count of slots consumed this cycle (buffer pop count).
- out_valid  out  NUM_UNITS  registered single-cycle dispatch strobe per unit.
- out_inst  out  NUM_UNITS*64  registered payload per unit.
- out_warp  out  NUM_UNITS*WID_W  registered warp id per unit.
- wb_valid  in  WB_PORTS; wb_warp  in  WB_PORTS*WID_W; wb_rd  in  WB_PORTS*REG_W  scoreboard release.
- flush, flush_warp  in  1, WID_W  clear all scoreboard bits of flush_warp.
- cnt_full, cnt_partial, cnt_stall  out  32 each  saturating statistics counters.

## Operation
- Scoreboard: NUM_WARPS x NUM_REGS bit array, 1 = write pending.
- Slot k is eligible only if all of the following hold:
  - in_valid[k] is set, k < effective cap, and slot k-1 issued (in-order prefix).
  - in_unit[k] < NUM_UNITS, unit_ready is set for that unit, and no earlier slot this cycle claimed the same unit.
  - No enabled source and no enabled rd of slot k hits a set scoreboard bit (registered state; no writeback bypass).
  - No enabled source or rd of slot k equals the rd of an earlier issuing slot with wr_en set (intra-group RAW/WAW).
  - flush is not asserted for in_warp.
- issue_count = number of eligible prefix slots.
- On clk, for each issued slot: out_valid[unit]<=1, and payload/warp are latched to that unit. The scoreboard bit (in_warp, rd) is set if wr_en. Unclaimed units get out_valid<=0.
- On clk, for each wb_valid port, the bit (wb_warp, wb_rd) is cleared. Duplicate clears are harmless.
- flush clears the entire row of flush_warp. Same-cycle writebacks to that warp are subsumed by the flush.
- A set and a clear of the same bit in one cycle cannot occur, because the WAW check stalls the issue.
- Counters, evaluated when in_valid[0]=1:
  - issue_count == effective cap: cnt_full++.
  - 0 < issue_count < cap: cnt_partial++.
  - issue_count == 0: cnt_stall++.
  - All counters saturate at 0xFFFFFFFF.

## Timing
- Reset (async assert): out_valid=0, out_inst=0, out_warp=0, scoreboard all 0, all counters 0. issue_count is 0 while rst is high.
- Decision to dispatch latency: 1 cycle. Scoreboard update is visible to the decision on the next cycle.
- A dependent instruction reading rd issued in cycle T is blocked at least until the writeback cycle W, and can issue at W+1 at the earliest.
- Reset mid-operation discards all pending scoreboard state; in-flight ops are not tracked.
- in_valid=0 in all slots: issue_count=0, out_valid=0, counters unchanged.

## Test plan
- Independence: R5=ADD(R1,R2) on unit 0 and R6=FADD(R3,R4) on unit 1, all ready, warp 0 → issue_count=2; next cycle out_valid=3'b011; sb[0][5] and sb[0][6] set; cnt_full=1.
- Unit conflict: both slots target unit 0 → issue_count=1, cnt_partial=1. Next cycle slot 1 re-presented in slot 0 → issues.
- Hazards:
  - RAW: slot 1 reads R3 written by slot 0 → issue_count=1.
  - Pending R3 (no writeback): slot 0 reading R3 → issue_count=0, cnt_stall increments each cycle.
  - After wb_valid with warp 0, rd 3: issue occurs exactly 1 cycle later.
- max_issue=1 with two independent slots → issue_count=1 every cycle; full counted as cnt_full.
- Flush/reset:
  - Warp 2 sets R7; flush with flush_warp=2 → R7 reader issues next cycle. Warp 3 bits are unaffected.
  - Flush of in_warp → issue_count=0 that cycle.
  - Asynchronous rst mid-stream → out_valid=0 immediately, counters 0.
- Saturation: force cnt_stall to 0xFFFFFFFE, stall 3 cycles → cnt_stall=0xFFFFFFFF.

Source files
------------

// File: rtl/issue_dispatch_unit.sv
// N-wide in-order issue stage: dispatches the longest legal prefix of one warp's
// instruction group to the unit ports and tracks a per-warp register scoreboard.
module issue_dispatch_unit #(
  parameter int  ISSUE_WIDTH = 2,
  parameter int  NUM_UNITS   = 3,
  parameter int  NUM_WARPS   = 24,
  parameter int  NUM_REGS    = 64,
  parameter int  WB_PORTS    = 2,
  localparam int WID_W       = $clog2(NUM_WARPS),
  localparam int REG_W       = $clog2(NUM_REGS),
  localparam int UNIT_W      = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  localparam int CNT_W       = $clog2(ISSUE_WIDTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ISSUE_WIDTH-1:0]        in_valid_i,
  input  logic [WID_W-1:0]              in_warp_i,
  input  logic [ISSUE_WIDTH*64-1:0]     in_inst_i,
  input  logic [ISSUE_WIDTH*UNIT_W-1:0] in_unit_i,
  input  logic [ISSUE_WIDTH*REG_W-1:0]  in_rd_i,
  input  logic [ISSUE_WIDTH*REG_W-1:0]  in_rs1_i,
  input  logic [ISSUE_WIDTH*REG_W-1:0]  in_rs2_i,
  input  logic [ISSUE_WIDTH*REG_W-1:0]  in_rs3_i,
  input  logic [ISSUE_WIDTH-1:0]        in_wr_en_i,
  input  logic [ISSUE_WIDTH*3-1:0]      in_src_en_i,
  input  logic [CNT_W-1:0]              max_issue_i,
  input  logic [NUM_UNITS-1:0]          unit_ready_i,
  output logic [CNT_W-1:0]              issue_count_o,
  output logic [NUM_UNITS-1:0]          out_valid_o,
  output logic [NUM_UNITS*64-1:0]       out_inst_o,
  output logic [NUM_UNITS*WID_W-1:0]    out_warp_o,
  input  logic [WB_PORTS-1:0]           wb_valid_i,
  input  logic [WB_PORTS*WID_W-1:0]     wb_warp_i,
  input  logic [WB_PORTS*REG_W-1:0]     wb_rd_i,
  input  logic                          flush_i,
  input  logic [WID_W-1:0]              flush_warp_i,
  output logic [31:0]                   cnt_full_o,
  output logic [31:0]                   cnt_partial_o,
  output logic [31:0]                   cnt_stall_o
);

  localparam int UNIT_SLOTS = 1 << UNIT_W;

  logic [NUM_REGS-1:0]        sb_q [NUM_WARPS];
  logic [NUM_REGS-1:0]        sb_d [NUM_WARPS];
  logic [NUM_UNITS-1:0]       out_valid_q, out_valid_d;
  logic [NUM_UNITS*64-1:0]    out_inst_q, out_inst_d;
  logic [NUM_UNITS*WID_W-1:0] out_warp_q, out_warp_d;
  logic [31:0]                cnt_full_q, cnt_full_d;
  logic [31:0]                cnt_partial_q, cnt_partial_d;
  logic [31:0]                cnt_stall_q, cnt_stall_d;

  logic [CNT_W-1:0]           cap;
  logic [CNT_W-1:0]           count;
  logic [ISSUE_WIDTH-1:0]     issue_mask;
  logic [NUM_REGS-1:0]        row, grp_wr, need;
  logic [UNIT_SLOTS-1:0]      ready_pad, claimed;
  logic [UNIT_W-1:0]          unit;
  logic [REG_W-1:0]           rd;
  logic                       chain, ok, flush_hit;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign cap = (max_issue_i == '0 || max_issue_i > CNT_W'(ISSUE_WIDTH))
               ? CNT_W'(ISSUE_WIDTH) : max_issue_i;
  assign flush_hit = flush_i && (flush_warp_i == in_warp_i);
  assign row = (int'(in_warp_i) < NUM_WARPS) ? sb_q[in_warp_i] : '0;

  // NOTE: every variable gets a default before the loop so no path leaves one
  // unassigned (no latch); blocking '=' lets each slot see earlier slots' claims.
  always_comb begin
    ready_pad                = '0;
    ready_pad[NUM_UNITS-1:0] = unit_ready_i;
    claimed     = '0;
    issue_mask  = '0;
    grp_wr      = '0;
    need        = '0;
    count       = '0;
    unit        = '0;
    rd          = '0;
    ok          = 1'b0;
    out_valid_d = '0;
    out_inst_d  = out_inst_q;
    out_warp_d  = out_warp_q;
    chain       = !rst && !flush_hit;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      unit = in_unit_i[k*UNIT_W +: UNIT_W];
      rd   = in_rd_i[k*REG_W +: REG_W];
      need = '0;
      if (in_src_en_i[3*k])   need[in_rs1_i[k*REG_W +: REG_W]] = 1'b1;
      if (in_src_en_i[3*k+1]) need[in_rs2_i[k*REG_W +: REG_W]] = 1'b1;
      if (in_src_en_i[3*k+2]) need[in_rs3_i[k*REG_W +: REG_W]] = 1'b1;
      if (in_wr_en_i[k])      need[rd] = 1'b1;
      // Pending writes come from the registered scoreboard plus earlier slots of this group.
      ok = chain && in_valid_i[k] && (CNT_W'(k) < cap)
           && (int'(unit) < NUM_UNITS) && ready_pad[unit] && !claimed[unit]
           && ((need & (row | grp_wr)) == '0);
      if (ok) begin
        issue_mask[k]                   = 1'b1;
        claimed[unit]                   = 1'b1;
        count                           = count + CNT_W'(1);
        out_valid_d[unit]               = 1'b1;
        out_inst_d[unit*64 +: 64]       = in_inst_i[k*64 +: 64];
        out_warp_d[unit*WID_W +: WID_W] = in_warp_i;
        if (in_wr_en_i[k]) grp_wr[rd] = 1'b1;
      end
      chain = ok;
    end
  end

  assign issue_count_o = count;

  always_comb begin
    sb_d = sb_q;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      if (issue_mask[k] && in_wr_en_i[k] && int'(in_warp_i) < NUM_WARPS)
        sb_d[in_warp_i][in_rd_i[k*REG_W +: REG_W]] = 1'b1;
    end
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid_i[p] && int'(wb_warp_i[p*WID_W +: WID_W]) < NUM_WARPS)
        sb_d[wb_warp_i[p*WID_W +: WID_W]][wb_rd_i[p*REG_W +: REG_W]] = 1'b0;
    end
    if (flush_i && int'(flush_warp_i) < NUM_WARPS) sb_d[flush_warp_i] = '0;
  end

  always_comb begin
    cnt_full_d    = cnt_full_q;
    cnt_partial_d = cnt_partial_q;
    cnt_stall_d   = cnt_stall_q;
    if (in_valid_i[0]) begin
      if (count == cap)       cnt_full_d    = sat_inc(cnt_full_q);
      else if (count != '0)   cnt_partial_d = sat_inc(cnt_partial_q);
      else                    cnt_stall_d   = sat_inc(cnt_stall_q);
    end
  end

  // NOTE: the scoreboard array is reset explicitly because a reset must drop all
  // pending writes; sequential state uses non-blocking '<=' only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= '0;
      out_inst_q    <= '0;
      out_warp_q    <= '0;
      cnt_full_q    <= '0;
      cnt_partial_q <= '0;
      cnt_stall_q   <= '0;
      for (int w = 0; w < NUM_WARPS; w++) sb_q[w] <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_inst_q    <= out_inst_d;
      out_warp_q    <= out_warp_d;
      cnt_full_q    <= cnt_full_d;
      cnt_partial_q <= cnt_partial_d;
      cnt_stall_q   <= cnt_stall_d;
      sb_q          <= sb_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_inst_o    = out_inst_q;
  assign out_warp_o    = out_warp_q;
  assign cnt_full_o    = cnt_full_q;
  assign cnt_partial_o = cnt_partial_q;
  assign cnt_stall_o   = cnt_stall_q;

endmodule
